regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port integer register file with a per-register busy scoreboard, the next-generation register file for the core. It provides NR combinational read ports and NW synchronous write ports with x0 hardwired to zero, and tracks outstanding producers so decode can stall on RAW hazards. It sits between decode/issue (read and issue-mark) and writeback (write and busy-clear). An optional bypass forwards same-cycle writeback data to the read ports.

## Interface
- DW, 64, data width in bits
- AW, 5, address width; register count RC = 2**AW
- NR, 2, number of read ports (1..4)
- NW, 2, number of write ports (1..2)

- i_clk  in  1  clock, all state updates on rising edge
- i_rst  in  1  asynchronous, active-high reset
- i_wen  in  NW  write enable per write port
- i_waddr  in  NW*AW  write addresses, port k at [k*AW +: AW]
- i_wdata  in  NW*DW  write data, port k at [k*DW +: DW]
- i_iss_vld  in  1  issue marks a destination busy
- i_iss_addr  in  AW  destination register being issued
- i_raddr  in  NR*AW  read addresses
- o_rdata  out  NR*DW  read data
- o_rbusy  out  NR  addressed register has an outstanding producer
- s_a0zero  out  1  sim only: 1 when x10 == 0

## Operation
- State: rf[RC] of DW bits, busy[RC] of 1 bit.
- Reset (i_rst=1, asynchronous): all rf entries 0, all busy 0; immediately o_rdata=0, o_rbusy=0, s_a0zero=1.
- Write: on edge, for each k with i_wen[k]=1 and i_waddr[k]!=0, rf[addr] <= wdata[k]. Two ports to the same address in one cycle: highest port index wins.
- x0: never written, never busy, always reads 0, regardless of wen/iss.
- Busy set: i_iss_vld=1 and i_iss_addr!=0 sets busy[i_iss_addr] on the edge.
- Busy clear: any i_wen[k]=1 to address a clears busy[a] on the edge.
- Same-edge set and clear of the same address: set wins (a newer producer is issued); busy stays 1.
- i_iss_vld with i_iss_addr=0: ignored.
- Read: o_rdata[r] = rf[i_raddr[r]] (0 for x0); o_rbusy[r] = busy[i_raddr[r]] (0 for x0), subject to bypass below.
- Reset asserted mid-write: reset dominates; no write lands.

## Timing
- Read data and busy: combinational from i_raddr, zero latency.
- Writes become architecturally visible on the cycle after i_wen (without bypass).
- Busy set visible on the cycle after i_iss_vld; busy clear visible on the cycle after i_wen (without bypass).
- No handshake; write and issue ports are single-cycle qualified by i_wen/i_iss_vld.
- s_a0zero reflects registered rf[10] only, never bypassed.

## Configuration
- REGFILE_BYPASS_EN defined: if any i_wen[k]=1 with i_waddr[k]==i_raddr[r]!=0 in the current cycle, o_rdata[r] = i_wdata[k] (highest k wins) and o_rbusy[r] = 0 in the same cycle. Registered state updates are unchanged.
- Not defined: no forwarding; reads return registered contents only, write-then-read needs one cycle.

## Test plan
- Reset: assert i_rst mid-run with rf[5]=0x1234 and busy[5]=1 -> o_rdata for raddr=5 is 0 and o_rbusy=0 without a clock edge; s_a0zero=1.
- x0: i_wen[0]=1, waddr=0, wdata=0xDEAD; i_iss_vld=1, iss_addr=0 -> next cycle raddr=0 reads 0, o_rbusy=0.
- Dual write collision: port0 writes x7=0x11, port1 writes x7=0x22 in the same cycle -> next cycle x7 reads 0x22.
- Scoreboard: issue x3 at cycle n -> o_rbusy=1 from n+1; write x3=0x55 at cycle m -> o_rbusy=0 and data 0x55 at m+1 (same cycle m with REGFILE_BYPASS_EN).
- Set/clear race: busy[9]=1; same cycle i_wen to x9 and i_iss_vld to x9 -> x9 data updated, o_rbusy stays 1.
- Bypass: with REGFILE_BYPASS_EN, write x10=0 while raddr0=10 -> o_rdata=0 same cycle, s_a0zero changes only after the edge; without the macro, o_rdata shows the old value until the edge.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-port integer register file with per-register busy scoreboard; x0 reads zero.
// Optional same-cycle writeback forwarding to the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp #(
  parameter int DW = 64,
  parameter int AW = 5,
  parameter int NR = 2,
  parameter int NW = 2
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [NW-1:0]    i_wen,
  input  logic [NW*AW-1:0] i_waddr,
  input  logic [NW*DW-1:0] i_wdata,
  input  logic             i_iss_vld,
  input  logic [AW-1:0]    i_iss_addr,
  input  logic [NR*AW-1:0] i_raddr,
  output logic [NR*DW-1:0] o_rdata,
  output logic [NR-1:0]    o_rbusy,
  output logic             s_a0zero
);

  localparam int RC = 2 ** AW;
  localparam int unsigned A0_IDX = 10;

  logic [DW-1:0] rf_q [RC];
  logic [RC-1:0] busy_q;
  logic [RC-1:0] busy_d;

  // Issue is applied after the writeback clears so a newer producer keeps the register busy.
  always_comb begin
    busy_d = busy_q;
    for (int unsigned k = 0; k < NW; k++) begin
      if (i_wen[k]) begin
        busy_d[i_waddr[k*AW +: AW]] = 1'b0;
      end
    end
    if (i_iss_vld && (i_iss_addr != '0)) begin
      busy_d[i_iss_addr] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < RC; i++) begin
        rf_q[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      // Ascending port order: the last non-blocking assignment, i.e. the highest port, wins.
      for (int unsigned k = 0; k < NW; k++) begin
        if (i_wen[k] && (i_waddr[k*AW +: AW] != '0)) begin
          rf_q[i_waddr[k*AW +: AW]] <= i_wdata[k*DW +: DW];
        end
      end
      busy_q <= busy_d;
    end
  end

  logic [AW-1:0] ra;

  always_comb begin
    o_rdata = '0;
    o_rbusy = '0;
    ra      = '0;
    for (int unsigned r = 0; r < NR; r++) begin
      ra = i_raddr[r*AW +: AW];
      o_rdata[r*DW +: DW] = rf_q[ra];
      o_rbusy[r]          = busy_q[ra];
`ifdef REGFILE_BYPASS_EN
      for (int unsigned k = 0; k < NW; k++) begin
        if (i_wen[k] && (i_waddr[k*AW +: AW] == ra)) begin
          o_rdata[r*DW +: DW] = i_wdata[k*DW +: DW];
          o_rbusy[r]          = 1'b0;
        end
      end
`endif
      // Reset must show zero immediately, even while a write is being forwarded.
      if ((ra == '0) || i_rst) begin
        o_rdata[r*DW +: DW] = '0;
        o_rbusy[r]          = 1'b0;
      end
    end
  end

  generate
    if (RC > A0_IDX) begin : g_a0
      assign s_a0zero = (rf_q[A0_IDX[AW-1:0]] == '0);
    end else begin : g_no_a0
      assign s_a0zero = 1'b1;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp; expectations follow REGFILE_BYPASS_EN when defined.
module tb_regfile_mp;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int NR = 2;
  localparam int NW = 2;

  logic             i_clk = 1'b0;
  logic             i_rst = 1'b0;
  logic [NW-1:0]    i_wen;
  logic [NW*AW-1:0] i_waddr;
  logic [NW*DW-1:0] i_wdata;
  logic             i_iss_vld;
  logic [AW-1:0]    i_iss_addr;
  logic [NR*AW-1:0] i_raddr;
  logic [NR*DW-1:0] o_rdata;
  logic [NR-1:0]    o_rbusy;
  logic             s_a0zero;

  int pass_cnt  = 0;
  int total_cnt = 0;

  regfile_mp #(.DW(DW), .AW(AW), .NR(NR), .NW(NW)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_wen      (i_wen),
    .i_waddr    (i_waddr),
    .i_wdata    (i_wdata),
    .i_iss_vld  (i_iss_vld),
    .i_iss_addr (i_iss_addr),
    .i_raddr    (i_raddr),
    .o_rdata    (o_rdata),
    .o_rbusy    (o_rbusy),
    .s_a0zero   (s_a0zero)
  );

  always #5 i_clk = ~i_clk;

  task automatic idle();
    i_wen      = '0;
    i_waddr    = '0;
    i_wdata    = '0;
    i_iss_vld  = 1'b0;
    i_iss_addr = '0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    i_raddr = {5'd5, 5'd0};
    #2 i_rst = 1'b1;
    #1;
    total_cnt++;
    if ({o_rdata, o_rbusy, s_a0zero} !== {128'd0, 2'b00, 1'b1})
      $display("FAIL reset_initial rdata=%h busy=%b a0z=%b exp 0/00/1", o_rdata, o_rbusy, s_a0zero);
    else pass_cnt++;
    tick();
    tick();
    i_rst = 1'b0;
    i_wen = 2'b11; i_waddr = {5'd10, 5'd5}; i_wdata = {64'h99, 64'h1234};
    tick();
    idle();
    i_iss_vld = 1'b1; i_iss_addr = 5'd5;
    tick();
    idle();
    i_raddr = {5'd5, 5'd5};
    #1;
    total_cnt++;
    if ({o_rdata, o_rbusy, s_a0zero} !== {64'h1234, 64'h1234, 2'b11, 1'b0})
      $display("FAIL reset_preload rdata=%h busy=%b a0z=%b exp 1234/1234/11/0", o_rdata, o_rbusy, s_a0zero);
    else pass_cnt++;
    i_wen = 2'b01; i_waddr = {5'd0, 5'd5}; i_wdata = {64'd0, 64'hBEEF};
    #2 i_rst = 1'b1;
    #1;
    total_cnt++;
    if ({o_rdata, o_rbusy, s_a0zero} !== {128'd0, 2'b00, 1'b1})
      $display("FAIL reset_async rdata=%h busy=%b a0z=%b exp 0/00/1", o_rdata, o_rbusy, s_a0zero);
    else pass_cnt++;
    tick();
    idle();
    i_rst = 1'b0;
    #1;
    total_cnt++;
    if ({o_rdata, o_rbusy} !== {128'd0, 2'b00})
      $display("FAIL reset_blocks_write rdata=%h busy=%b exp 0/00", o_rdata, o_rbusy);
    else pass_cnt++;
  endtask

  task automatic test_x0();
    tick();
    i_wen = 2'b11; i_waddr = {5'd0, 5'd0}; i_wdata = {64'hBEEF, 64'hDEAD};
    i_iss_vld = 1'b1; i_iss_addr = 5'd0;
    i_raddr = {5'd0, 5'd0};
    #1;
    total_cnt++;
    if ({o_rdata, o_rbusy} !== {128'd0, 2'b00})
      $display("FAIL x0_same_cycle rdata=%h busy=%b exp 0/00", o_rdata, o_rbusy);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if ({o_rdata, o_rbusy} !== {128'd0, 2'b00})
      $display("FAIL x0_after rdata=%h busy=%b exp 0/00", o_rdata, o_rbusy);
    else pass_cnt++;
  endtask

  task automatic test_collision();
    i_wen = 2'b11; i_waddr = {5'd7, 5'd7}; i_wdata = {64'h22, 64'h11};
    tick();
    idle();
    i_raddr = {5'd7, 5'd7};
    #1;
    total_cnt++;
    if (o_rdata !== {64'h22, 64'h22})
      $display("FAIL collision rdata=%h exp 22/22", o_rdata);
    else pass_cnt++;
  endtask

  task automatic test_scoreboard();
    i_raddr = {5'd3, 5'd0};
    i_iss_vld = 1'b1; i_iss_addr = 5'd3;
    #1;
    total_cnt++;
    if (o_rbusy !== 2'b00)
      $display("FAIL sb_before_edge busy=%b exp 00", o_rbusy);
    else pass_cnt++;
    tick();
    idle();
    #1;
    total_cnt++;
    if (o_rbusy !== 2'b10)
      $display("FAIL sb_set busy=%b exp 10", o_rbusy);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (o_rbusy !== 2'b10)
      $display("FAIL sb_hold busy=%b exp 10", o_rbusy);
    else pass_cnt++;
    i_wen = 2'b10; i_waddr = {5'd3, 5'd0}; i_wdata = {64'h55, 64'hAA};
    #1;
    total_cnt++;
`ifdef REGFILE_BYPASS_EN
    if ({o_rdata[2*DW-1:DW], o_rbusy} !== {64'h55, 2'b00})
      $display("FAIL sb_write_same_cycle rdata=%h busy=%b exp 55/00", o_rdata[2*DW-1:DW], o_rbusy);
    else pass_cnt++;
`else
    if ({o_rdata[2*DW-1:DW], o_rbusy} !== {64'h0, 2'b10})
      $display("FAIL sb_write_same_cycle rdata=%h busy=%b exp 0/10", o_rdata[2*DW-1:DW], o_rbusy);
    else pass_cnt++;
`endif
    tick();
    idle();
    #1;
    total_cnt++;
    if ({o_rdata[2*DW-1:DW], o_rbusy} !== {64'h55, 2'b00})
      $display("FAIL sb_cleared rdata=%h busy=%b exp 55/00", o_rdata[2*DW-1:DW], o_rbusy);
    else pass_cnt++;
  endtask

  task automatic test_race();
    i_iss_vld = 1'b1; i_iss_addr = 5'd9;
    tick();
    idle();
    i_wen = 2'b01; i_waddr = {5'd0, 5'd9}; i_wdata = {64'd0, 64'hAB};
    i_iss_vld = 1'b1; i_iss_addr = 5'd9;
    tick();
    idle();
    i_raddr = {5'd9, 5'd9};
    #1;
    total_cnt++;
    if ({o_rdata, o_rbusy} !== {64'hAB, 64'hAB, 2'b11})
      $display("FAIL race rdata=%h busy=%b exp AB/AB/11", o_rdata, o_rbusy);
    else pass_cnt++;
  endtask

  task automatic test_bypass();
    i_wen = 2'b01; i_waddr = {5'd0, 5'd10}; i_wdata = {64'd0, 64'h77};
    tick();
    idle();
    i_raddr = {5'd0, 5'd10};
    #1;
    total_cnt++;
    if ({o_rdata[DW-1:0], s_a0zero} !== {64'h77, 1'b0})
      $display("FAIL a0_written rdata=%h a0z=%b exp 77/0", o_rdata[DW-1:0], s_a0zero);
    else pass_cnt++;
    i_wen = 2'b10; i_waddr = {5'd10, 5'd0}; i_wdata = {64'd0, 64'hFF};
    #1;
    total_cnt++;
`ifdef REGFILE_BYPASS_EN
    if ({o_rdata[DW-1:0], s_a0zero} !== {64'h0, 1'b0})
      $display("FAIL bypass_same_cycle rdata=%h a0z=%b exp 0/0", o_rdata[DW-1:0], s_a0zero);
    else pass_cnt++;
`else
    if ({o_rdata[DW-1:0], s_a0zero} !== {64'h77, 1'b0})
      $display("FAIL bypass_same_cycle rdata=%h a0z=%b exp 77/0", o_rdata[DW-1:0], s_a0zero);
    else pass_cnt++;
`endif
    tick();
    idle();
    #1;
    total_cnt++;
    if ({o_rdata[DW-1:0], s_a0zero} !== {64'h0, 1'b1})
      $display("FAIL bypass_after_edge rdata=%h a0z=%b exp 0/1", o_rdata[DW-1:0], s_a0zero);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    i_wen = 2'b01; i_waddr = {5'd0, 5'd12}; i_wdata = {64'd0, 64'h1};
    tick();
    i_wdata = {64'd0, 64'h2};
    i_waddr = {5'd0, 5'd13};
    tick();
    idle();
    i_raddr = {5'd13, 5'd12};
    #1;
    total_cnt++;
    if (o_rdata !== {64'h2, 64'h1})
      $display("FAIL back_to_back rdata=%h exp 2/1", o_rdata);
    else pass_cnt++;
  endtask

  initial begin
    idle();
    i_raddr = '0;
    test_reset();
    test_x0();
    test_collision();
    test_scoreboard();
    test_race();
    test_bypass();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
